load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns a MEM-stage access into a single-beat data-memory bus
// transaction with byte-lane steering on stores and lane extraction/extension on loads.
package load_store_unit_pkg;
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } mem_size_t;
endpackage

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_req,
  input  logic              ex_wr_en,
  input  mem_size_t         ex_size,
  input  logic              ex_zero_extend,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              lsu_stall,
  output logic              lsu_misaligned,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_rdata_valid,
  output logic              dmem_bus_req,
  output logic              dmem_bus_we,
  output logic [ADDR_W-1:0] dmem_bus_addr,
  output logic [3:0]        dmem_bus_be,
  output logic [31:0]       dmem_bus_wdata,
  input  logic              dmem_bus_gnt,
  input  logic              dmem_bus_rvalid,
  input  logic [31:0]       dmem_bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state;
  mem_size_t   r_size;
  logic        r_zext;
  logic [1:0]  r_off;

  logic        legal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic        accept;

  // Alignment check plus store lane steering, decoded straight from the EX inputs.
  always_comb begin
    legal      = 1'b0;
    be_next    = '0;
    wdata_next = ex_wdata;
    case (ex_size)
      BYTE: begin
        legal      = 1'b1;
        be_next    = 4'b0001 << ex_addr[1:0];
        wdata_next = {4{ex_wdata[7:0]}};
      end
      HALF_WORD: begin
        legal      = ~ex_addr[0];
        be_next    = ex_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{ex_wdata[15:0]}};
      end
      WORD: begin
        legal      = (ex_addr[1:0] == 2'b00);
        be_next    = 4'b1111;
        wdata_next = ex_wdata;
      end
      default: begin
        legal      = 1'b0;
        be_next    = '0;
        wdata_next = ex_wdata;
      end
    endcase
  end

  assign accept = (state == S_IDLE) && ex_req && legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      dmem_bus_we    <= 1'b0;
      dmem_bus_addr  <= '0;
      dmem_bus_be    <= '0;
      dmem_bus_wdata <= '0;
      r_size         <= BYTE;
      r_zext         <= 1'b0;
      r_off          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state          <= S_REQ;
            dmem_bus_we    <= ex_wr_en;
            dmem_bus_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
            dmem_bus_be    <= be_next;
            dmem_bus_wdata <= wdata_next;
            r_size         <= ex_size;
            r_zext         <= ex_zero_extend;
            r_off          <= ex_addr[1:0];
          end
        end
        S_REQ: begin
          if (dmem_bus_gnt) begin
            state <= dmem_bus_we ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_bus_rvalid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Load lane selection uses the offset captured at issue, not the live EX address.
  always_comb begin
    case (r_off)
      2'd0:    lane_byte = dmem_bus_rdata[7:0];
      2'd1:    lane_byte = dmem_bus_rdata[15:8];
      2'd2:    lane_byte = dmem_bus_rdata[23:16];
      default: lane_byte = dmem_bus_rdata[31:24];
    endcase
    lane_half = r_off[1] ? dmem_bus_rdata[31:16] : dmem_bus_rdata[15:0];
    case (r_size)
      BYTE:      load_ext = {{24{~r_zext & lane_byte[7]}}, lane_byte};
      HALF_WORD: load_ext = {{16{~r_zext & lane_half[15]}}, lane_half};
      default:   load_ext = dmem_bus_rdata;
    endcase
  end

  always_comb begin
    lsu_misaligned  = 1'b0;
    lsu_stall       = 1'b0;
    lsu_rdata_valid = 1'b0;
    dmem_bus_req    = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          lsu_misaligned = ex_req && !legal;
          lsu_stall      = accept;
        end
        S_REQ: begin
          dmem_bus_req = 1'b1;
          lsu_stall    = !(dmem_bus_gnt && dmem_bus_we);
        end
        S_WAIT: begin
          lsu_stall       = !dmem_bus_rvalid;
          lsu_rdata_valid = dmem_bus_rvalid;
        end
        default: ;
      endcase
    end
    lsu_rdata = lsu_rdata_valid ? load_ext : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses checked
// against a lane-arithmetic reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_req;
  logic        ex_wr_en;
  mem_size_t   ex_size;
  logic        ex_zero_extend;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        lsu_stall;
  logic        lsu_misaligned;
  logic [31:0] lsu_rdata;
  logic        lsu_rdata_valid;
  logic        dmem_bus_req;
  logic        dmem_bus_we;
  logic [31:0] dmem_bus_addr;
  logic [3:0]  dmem_bus_be;
  logic [31:0] dmem_bus_wdata;
  logic        dmem_bus_gnt;
  logic        dmem_bus_rvalid;
  logic [31:0] dmem_bus_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_req         (ex_req),
    .ex_wr_en       (ex_wr_en),
    .ex_size        (ex_size),
    .ex_zero_extend (ex_zero_extend),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .lsu_stall      (lsu_stall),
    .lsu_misaligned (lsu_misaligned),
    .lsu_rdata      (lsu_rdata),
    .lsu_rdata_valid(lsu_rdata_valid),
    .dmem_bus_req   (dmem_bus_req),
    .dmem_bus_we    (dmem_bus_we),
    .dmem_bus_addr  (dmem_bus_addr),
    .dmem_bus_be    (dmem_bus_be),
    .dmem_bus_wdata (dmem_bus_wdata),
    .dmem_bus_gnt   (dmem_bus_gnt),
    .dmem_bus_rvalid(dmem_bus_rvalid),
    .dmem_bus_rdata (dmem_bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes, 0 for an illegal size code.
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic [1:0] sz, input logic [31:0] addr);
    int n = nbytes(sz);
    return (n != 0) && ((addr % n) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
    int n = nbytes(sz);
    int off = int'(addr % 4);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    logic [31:0] o = '0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit zext,
                                             input logic [31:0] addr, input logic [31:0] word);
    int n = nbytes(sz);
    logic [31:0] v = word >> (8 * (addr % 4));
    logic [31:0] mask;
    if (n == 4) return word;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = v & mask;
    if (!zext && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Runs one access from IDLE; EX inputs and stray gnt/rvalid are randomized while busy.
  task automatic access(input bit we, input logic [1:0] sz, input bit zext,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] word,
                        output logic [31:0] got);
    bit ok = model_legal(sz, addr);
    got = '0;
    ex_req = 1'b1; ex_wr_en = we; ex_size = mem_size_t'(sz); ex_zero_extend = zext;
    ex_addr = addr; ex_wdata = wd; dmem_bus_gnt = 1'b0; dmem_bus_rvalid = 1'b0;
    #1;
    chk("idle_stall", 32'(lsu_stall), 32'(ok));
    chk("idle_misaligned", 32'(lsu_misaligned), 32'(!ok));
    chk("idle_bus_req", 32'(dmem_bus_req), 32'd0);
    step();
    if (!ok) begin
      ex_req = 1'b0;
      #1;
      chk("mis_no_bus_req", 32'(dmem_bus_req), 32'd0);
      chk("mis_stays_idle", 32'(lsu_stall), 32'd0);
      return;
    end
    for (int k = 0; k <= gd; k++) begin
      ex_req = 1'($urandom); ex_wr_en = 1'($urandom); ex_size = mem_size_t'(2'($urandom));
      ex_addr = $urandom; ex_wdata = $urandom;
      dmem_bus_gnt = (k == gd); dmem_bus_rvalid = 1'($urandom); dmem_bus_rdata = $urandom;
      #1;
      chk("req_bus_req", 32'(dmem_bus_req), 32'd1);
      chk("req_we", 32'(dmem_bus_we), 32'(we));
      chk("req_addr", dmem_bus_addr, {addr[31:2], 2'b00});
      chk("req_be", 32'(dmem_bus_be), 32'(model_be(sz, addr)));
      chk("req_wdata", dmem_bus_wdata, model_wdata(sz, wd));
      chk("req_stall", 32'(lsu_stall), 32'(!((k == gd) && we)));
      chk("req_rdata_valid", 32'(lsu_rdata_valid), 32'd0);
      chk("req_rdata_zero", lsu_rdata, 32'd0);
      chk("req_misaligned", 32'(lsu_misaligned), 32'd0);
      step();
    end
    if (!we) begin
      for (int k = 0; k <= rd; k++) begin
        ex_req = 1'($urandom); ex_addr = $urandom;
        dmem_bus_gnt = 1'($urandom); dmem_bus_rvalid = (k == rd);
        dmem_bus_rdata = (k == rd) ? word : $urandom;
        #1;
        chk("wait_bus_req", 32'(dmem_bus_req), 32'd0);
        chk("wait_stall", 32'(lsu_stall), 32'(k != rd));
        chk("wait_rdata_valid", 32'(lsu_rdata_valid), 32'(k == rd));
        chk("wait_rdata", lsu_rdata, (k == rd) ? model_load(sz, zext, addr, word) : 32'd0);
        if (k == rd) got = lsu_rdata;
        step();
      end
    end
    ex_req = 1'b0; dmem_bus_gnt = 1'b0; dmem_bus_rvalid = 1'b0;
  endtask

  logic [31:0] got;

  initial begin
    rst = 1'b1; ex_req = 1'b1; ex_wr_en = 1'b0; ex_size = mem_size_t'(2'b11);
    ex_zero_extend = 1'b0; ex_addr = 32'h3; ex_wdata = '0;
    dmem_bus_gnt = 1'b0; dmem_bus_rvalid = 1'b0; dmem_bus_rdata = '0;
    step();
    step();
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    chk("rst_misaligned", 32'(lsu_misaligned), 32'd0);
    chk("rst_rdata_valid", 32'(lsu_rdata_valid), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_bus_req", 32'(dmem_bus_req), 32'd0);
    chk("rst_bus_we", 32'(dmem_bus_we), 32'd0);
    chk("rst_bus_addr", dmem_bus_addr, 32'd0);
    chk("rst_bus_be", 32'(dmem_bus_be), 32'd0);
    chk("rst_bus_wdata", dmem_bus_wdata, 32'd0);
    rst = 1'b0; ex_req = 1'b0;
    step();

    // SW 0x104, immediate grant
    access(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0, got);
    // SB 0x103, grant after 3 cycles
    access(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 3, 0, 32'h0, got);
    // LB / LBU / LH at 0x202
    access(1'b0, 2'd0, 1'b0, 32'h202, 32'h0, 0, 0, 32'h1280FF34, got);
    chk("lb_0x202", got, 32'hFFFFFF80);
    access(1'b0, 2'd0, 1'b1, 32'h202, 32'h0, 1, 2, 32'h1280FF34, got);
    chk("lbu_0x202", got, 32'h00000080);
    access(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 0, 1, 32'h1280FF34, got);
    chk("lh_0x202", got, 32'h00001280);
    // Misaligned LW / LH
    access(1'b0, 2'd2, 1'b0, 32'h206, 32'h0, 0, 0, 32'h0, got);
    access(1'b0, 2'd1, 1'b0, 32'h201, 32'h0, 0, 0, 32'h0, got);

    // Reset while a load waits for rvalid; late rvalid must be ignored
    ex_req = 1'b1; ex_wr_en = 1'b0; ex_size = WORD; ex_addr = 32'h300; ex_zero_extend = 1'b0;
    #1;
    step();
    ex_req = 1'b0; dmem_bus_gnt = 1'b1;
    #1;
    chk("rw_req_stall", 32'(lsu_stall), 32'd1);
    step();
    dmem_bus_gnt = 1'b0; rst = 1'b1;
    #1;
    chk("rw_rst_stall", 32'(lsu_stall), 32'd0);
    step();
    rst = 1'b0; dmem_bus_rvalid = 1'b1; dmem_bus_rdata = 32'hCAFEF00D;
    #1;
    chk("rw_late_rvalid", 32'(lsu_rdata_valid), 32'd0);
    chk("rw_rdata", lsu_rdata, 32'd0);
    chk("rw_stall", 32'(lsu_stall), 32'd0);
    chk("rw_bus_req", 32'(dmem_bus_req), 32'd0);
    chk("rw_bus_addr", dmem_bus_addr, 32'd0);
    chk("rw_bus_be", 32'(dmem_bus_be), 32'd0);
    chk("rw_bus_wdata", dmem_bus_wdata, 32'd0);
    chk("rw_bus_we", 32'(dmem_bus_we), 32'd0);
    step();
    dmem_bus_rvalid = 1'b0;
    #1;
    chk("rw_idle_after", 32'(dmem_bus_req), 32'd0);
    step();

    // Back-to-back SW then LW, then confirm no repeated request
    access(1'b1, 2'd2, 1'b0, 32'h400, 32'h11223344, 0, 0, 32'h0, got);
    access(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 0, 0, 32'h89ABCDEF, got);
    chk("b2b_lw", got, 32'h89ABCDEF);
    #1;
    chk("b2b_no_dup_req", 32'(dmem_bus_req), 32'd0);
    chk("b2b_idle_stall", 32'(lsu_stall), 32'd0);
    step();

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [31:0] a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~32'(nbytes(sz) - 1);
      access(1'($urandom), sz, 1'($urandom), a, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
